// File: rtl/mod_counter.sv
// Up/down modulo counter with LIMIT/CTRL/STATUS registers on a shared tristate bus.
// Latency: register writes land at the next edge; reads and TC are combinational; no backpressure.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module mod_counter #(
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CS,
    input  logic                  WE,
    input  logic                  OE,
    input  logic [1:0]            ADDR,
    input  logic                  CNT_EN,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  TC
);

    localparam logic [1:0] A_COUNT  = 2'd0;
    localparam logic [1:0] A_LIMIT  = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] limit_q, limit_d;
    logic                  dir_q, dir_d;
    logic                  wrap_q, wrap_d;
    logic                  tc_flag_q, tc_flag_d;

    logic                  wr_en;
    logic                  rd_en;
    logic                  terminal;
    logic [DATA_WIDTH-1:0] rd_dat;

    assign wr_en = CS & WE;
    // A simultaneous OE+WE is a write, so the bus is never driven while WE is high.
    assign rd_en = CS & OE & ~WE;

    always_comb begin
        terminal = dir_q ? (count_q == '0) : (count_q == limit_q);
        TC       = CNT_EN & terminal;
    end

    always_comb begin
        count_d   = count_q;
        limit_d   = limit_q;
        dir_d     = dir_q;
        wrap_d    = wrap_q;
        tc_flag_d = tc_flag_q;

        if (wr_en && ADDR == A_COUNT) begin
            count_d = data;
        end else if (CNT_EN) begin
            if (terminal) begin
                if (wrap_q) begin
                    count_d = dir_q ? limit_q : '0;
                end
            end else begin
                count_d = dir_q ? count_q - 1'b1 : count_q + 1'b1;
            end
        end

        if (wr_en && ADDR == A_LIMIT) begin
            limit_d = data;
        end
        if (wr_en && ADDR == A_CTRL) begin
            dir_d  = data[0];
            wrap_d = data[1];
        end

        // Setting on terminal count beats a clear written in the same cycle.
        if (TC) begin
            tc_flag_d = 1'b1;
        end else if (wr_en && ADDR == A_STATUS && data[0]) begin
            tc_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            limit_q   <= '1;
            dir_q     <= 1'b0;
            wrap_q    <= 1'b1;
            tc_flag_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            limit_q   <= limit_d;
            dir_q     <= dir_d;
            wrap_q    <= wrap_d;
            tc_flag_q <= tc_flag_d;
        end
    end

    always_comb begin
        rd_dat = '0;
        case (ADDR)
            A_COUNT:  rd_dat = count_q;
            A_LIMIT:  rd_dat = limit_q;
            A_CTRL:   rd_dat[1:0] = {wrap_q, dir_q};
            A_STATUS: rd_dat[0] = tc_flag_q;
            default:  rd_dat = '0;
        endcase
    end

    assign data = rd_en ? rd_dat : 'z;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: a register-level reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mod_counter;

    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst, cs, we, oe, cnt_en;
    logic [1:0]   addr;
    logic         drv_en;
    logic [W-1:0] drv_val;
    logic         tc;
    tri   [W-1:0] data;

    int vectors    = 0;
    int miscompares = 0;
    bit started    = 1'b0;

    // Reference state as plain integers.
    int m_count, m_limit, m_dir, m_wrap, m_flag;

    assign data = drv_en ? drv_val : 'z;
    // Undriven bus reads back as all ones.
    for (genvar g = 0; g < W; g++) begin : g_pu
        pullup (data[g]);
    end

    always #5 clk = ~clk;

    mod_counter #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .reset  (rst),
        .CS     (cs),
        .WE     (we),
        .OE     (oe),
        .ADDR   (addr),
        .CNT_EN (cnt_en),
        .data   (data),
        .TC     (tc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_at_terminal();
        return (m_dir != 0) ? int'(m_count == 0) : int'(m_count == m_limit);
    endfunction

    function automatic int m_reg(input int a);
        case (a)
            0:       return m_count;
            1:       return m_limit;
            2:       return m_wrap * 2 + m_dir;
            default: return m_flag;
        endcase
    endfunction

    always @(posedge clk) begin
        int nc, nl, nd, nw, nf, term;
        if (rst) begin
            m_count = 0; m_limit = MOD - 1; m_dir = 0; m_wrap = 1; m_flag = 0;
        end else begin
            term = m_at_terminal();
            nc = m_count; nl = m_limit; nd = m_dir; nw = m_wrap; nf = m_flag;
            if (cs && we && addr == 0)      nc = drv_val;
            else if (cnt_en && term == 0)   nc = (m_dir != 0) ? (m_count + MOD - 1) % MOD : (m_count + 1) % MOD;
            else if (cnt_en && m_wrap != 0) nc = (m_dir != 0) ? m_limit : 0;
            if (cs && we && addr == 1) nl = drv_val;
            if (cs && we && addr == 2) begin nd = drv_val[0]; nw = drv_val[1]; end
            if (cnt_en && term != 0)                     nf = 1;
            else if (cs && we && addr == 3 && drv_val[0]) nf = 0;
            m_count = nc; m_limit = nl; m_dir = nd; m_wrap = nw; m_flag = nf;
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] exp_bus;
        if (started) begin
            check("tc_cycle", tc, cnt_en && m_at_terminal() != 0);
            if (cs && oe && !we) exp_bus = W'(m_reg(addr));
            else if (drv_en)     exp_bus = drv_val;
            else                 exp_bus = '1;
            check("bus_cycle", data, exp_bus);
        end
    end

    task automatic idle();
        cs = 0; we = 0; oe = 0; addr = 0; cnt_en = 0; drv_en = 0; drv_val = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] v, input logic en = 1'b0);
        cs = 1; we = 1; oe = 0; addr = a; drv_en = 1; drv_val = v; cnt_en = en;
        tick();
        idle();
    endtask

    task automatic rd(input logic [1:0] a, input logic [W-1:0] exp, input string name);
        cs = 1; oe = 1; we = 0; addr = a;
        #1;
        check(name, data, exp);
        idle();
    endtask

    task automatic run(input int n, input logic [15:0] exp_mask, input int exp_cnt, input string name);
        logic [15:0] mask = '0;
        int          cnt  = 0;
        cnt_en = 1;
        for (int i = 0; i < n; i++) begin
            #2;
            if (tc) begin
                cnt++;
                if (i < 16) mask[i] = 1'b1;
            end
            tick();
        end
        cnt_en = 0;
        check({name, "_tc_mask"}, mask, exp_mask);
        check({name, "_tc_count"}, cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        started = 1'b1;
        rst = 0;

        rd(0, 8'h00, "rst_count");
        rd(1, 8'hFF, "rst_limit");
        rd(2, 8'h02, "rst_ctrl");
        rd(3, 8'h00, "rst_status");
        check("rst_tc_idle", tc, 1'b0);

        // Full wrap at reset limit: TC only at 0xFF.
        run(256, 16'h0000, 1, "full");
        rd(0, 8'h00, "full_count");
        rd(3, 8'h01, "full_flag");
        wr(3, 8'h01);
        rd(3, 8'h00, "full_clr");

        // Up/wrap with LIMIT=5.
        wr(1, 8'd5); wr(2, 8'h02); wr(0, 8'd0);
        run(8, 16'b0010_0000, 1, "lim5");
        rd(0, 8'd2, "lim5_count");
        rd(3, 8'h01, "lim5_flag");
        wr(3, 8'h01);
        rd(3, 8'h00, "lim5_clr");

        // Down/wrap from 1 with LIMIT=3.
        wr(1, 8'd3); wr(2, 8'h03); wr(0, 8'd1);
        run(5, 16'b0_0010, 1, "down");
        rd(0, 8'd0, "down_count");

        // Up/hold at LIMIT=4.
        wr(2, 8'h00); wr(1, 8'd4); wr(0, 8'd0);
        run(7, 16'b111_0000, 3, "hold");
        rd(0, 8'd4, "hold_count");
        check("hold_tc_disabled", tc, 1'b0);

        // LIMIT=0 up: TC every enabled cycle for both WRAP settings.
        wr(1, 8'd0); wr(0, 8'd0);
        run(3, 16'b111, 3, "lim0_hold");
        wr(2, 8'h02);
        run(3, 16'b111, 3, "lim0_wrap");
        rd(0, 8'd0, "lim0_count");

        // Set beats clear on the same edge.
        wr(3, 8'h01, 1'b1);
        rd(3, 8'h01, "set_wins");

        // Above LIMIT: roll through all-ones to 0 without TC.
        wr(1, 8'd3); wr(0, 8'hFE);
        run(3, 16'h0000, 0, "above");
        rd(0, 8'd1, "above_count");

        // LIMIT write at a terminal edge uses the old LIMIT for that step.
        wr(1, 8'd5); wr(0, 8'd5);
        wr(1, 8'd9, 1'b1);
        rd(0, 8'd0, "old_limit_count");
        rd(1, 8'd9, "new_limit");

        // COUNT write beats the step.
        wr(0, 8'h20, 1'b1);
        rd(0, 8'h20, "wr_prio");

        // OE with WE is a write; CS low or OE low leaves the bus released.
        cs = 1; oe = 1; we = 1; addr = 3; drv_en = 1; drv_val = 8'h00;
        #1;
        check("oe_we_bus", data, 8'h00);
        tick();
        idle();
        cs = 0; oe = 1; addr = 0;
        #1;
        check("cs_low_hiz", data, 8'hFF);
        cs = 1; oe = 0;
        #1;
        check("oe_low_hiz", data, 8'hFF);
        idle();

        // Reset overrides a simultaneous LIMIT write and count.
        wr(0, 8'h37);
        cs = 1; we = 1; addr = 1; drv_en = 1; drv_val = 8'h10; cnt_en = 1; rst = 1;
        tick();
        rst = 0;
        idle();
        rd(0, 8'h00, "r34_count");
        rd(1, 8'hFF, "r34_limit");
        rd(2, 8'h02, "r34_ctrl");
        rd(3, 8'h00, "r34_status");

        tick();
        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
